// File: rtl/dcache_pkg.sv
// Shared definitions for the direct-mapped write-back L1 data cache:
// geometry, address slicing positions and the controller state encoding.
package dcache_pkg;

    localparam int ADDR_W    = 32;
    localparam int WORD_W    = 32;
    localparam int INDEX_W   = 5;
    localparam int OFFSET_W  = 3;
    localparam int BYTE_W    = 2;
    localparam int LINE_W    = 256;
    localparam int WORDS     = LINE_W / WORD_W;
    localparam int TAG_W     = ADDR_W - INDEX_W - OFFSET_W - BYTE_W;
    localparam int NUM_LINES = 1 << INDEX_W;
    localparam int INDEX_LSB = OFFSET_W + BYTE_W;
    localparam int TAG_LSB   = INDEX_LSB + INDEX_W;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WRITEBACK,
        ST_REFILL,
        ST_DONE
    } state_t;

    // Rebuilds the line-aligned byte address of a cache line from its tag and index.
    function automatic logic [ADDR_W-1:0] line_addr(input logic [TAG_W-1:0]   tag,
                                                    input logic [INDEX_W-1:0] idx);
        return {tag, idx, {INDEX_LSB{1'b0}}};
    endfunction

endpackage

// File: rtl/dcache_sram.sv
// Storage for the data cache: valid/dirty bits, tag array and line data array.
// Reads are asynchronous on the selected index; writes happen at the clock edge,
// either a whole line (refill, which also marks the line valid and clean) or a
// single word (store merge, which marks the line dirty).
module dcache_sram
    import dcache_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic [INDEX_W-1:0]  idx,
    output logic                rd_valid,
    output logic                rd_dirty,
    output logic [TAG_W-1:0]    rd_tag,
    output logic [LINE_W-1:0]   rd_line,
    input  logic                line_we,
    input  logic [TAG_W-1:0]    line_tag,
    input  logic [LINE_W-1:0]   line_data,
    input  logic                word_we,
    input  logic [OFFSET_W-1:0] word_sel,
    input  logic [WORD_W-1:0]   word_data
);

    logic [NUM_LINES-1:0]             valid_bits;
    logic [NUM_LINES-1:0]             dirty_bits;
    logic [TAG_W-1:0]                 tag_mem  [NUM_LINES];
    logic [WORDS-1:0][WORD_W-1:0]     data_mem [NUM_LINES];

    assign rd_valid = valid_bits[idx];
    assign rd_dirty = dirty_bits[idx];
    assign rd_tag   = tag_mem[idx];
    assign rd_line  = data_mem[idx];

    // Status bits are the only state cleared by reset; a refill makes a line clean, a store dirties it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_bits <= '0;
            dirty_bits <= '0;
        end else if (line_we) begin
            valid_bits[idx] <= 1'b1;
            dirty_bits[idx] <= 1'b0;
        end else if (word_we) begin
            dirty_bits[idx] <= 1'b1;
        end
    end

    // Tag and data contents need no reset because valid gates every use of them.
    always_ff @(posedge clk) begin
        if (line_we) begin
            tag_mem[idx]  <= line_tag;
            data_mem[idx] <= line_data;
        end else if (word_we) begin
            data_mem[idx][word_sel] <= word_data;
        end
    end

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate L1 data cache controller.
// Hits complete in the same cycle; misses stall the CPU while a dirty victim
// is written back and the line is refilled, then the access replays in DONE.
// Optional feature: define DCACHE_STATS_EN to add saturating hit/miss counters.
module dcache_ctrl
    import dcache_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              p1_req_i,
    input  logic              p1_write_i,
    input  logic [31:0]       p1_addr_i,
    input  logic [31:0]       p1_data_i,
    output logic [31:0]       p1_data_o,
    output logic              p1_stall_o,
    output logic              mem_enable_o,
    output logic              mem_write_o,
    output logic [31:0]       mem_addr_o,
    output logic [LINE_W-1:0] mem_data_o,
    input  logic [LINE_W-1:0] mem_data_i,
    input  logic              mem_ack_i
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0]       hit_cnt_o,
    output logic [31:0]       miss_cnt_o
`endif
);

    state_t              state;
    logic [INDEX_W-1:0]  idx;
    logic [TAG_W-1:0]    tag;
    logic [OFFSET_W-1:0] off;
    logic                rd_valid;
    logic                rd_dirty;
    logic [TAG_W-1:0]    rd_tag;
    logic [LINE_W-1:0]   rd_line;
    logic [WORD_W-1:0]   rd_word;
    logic                hit;
    logic                miss;
    logic                access_ok;
    logic                line_we;
    logic                word_we;

    assign idx = p1_addr_i[INDEX_LSB +: INDEX_W];
    assign tag = p1_addr_i[TAG_LSB +: TAG_W];
    assign off = p1_addr_i[BYTE_W +: OFFSET_W];

    dcache_sram u_sram (
        .clk       (clk_i),
        .rst       (rst_i),
        .idx       (idx),
        .rd_valid  (rd_valid),
        .rd_dirty  (rd_dirty),
        .rd_tag    (rd_tag),
        .rd_line   (rd_line),
        .line_we   (line_we),
        .line_tag  (tag),
        .line_data (mem_data_i),
        .word_we   (word_we),
        .word_sel  (off),
        .word_data (p1_data_i)
    );

    // Hit detection, stall and load-data muxing; all CPU-facing outputs are forced low during reset.
    always_comb begin
        rd_word    = rd_line[off*WORD_W +: WORD_W];
        hit        = rd_valid && (rd_tag == tag);
        miss       = (state == ST_IDLE) && p1_req_i && !hit;
        access_ok  = p1_req_i && (((state == ST_IDLE) && hit) || (state == ST_DONE));
        line_we    = (state == ST_REFILL) && mem_ack_i;
        word_we    = access_ok && p1_write_i;
        p1_stall_o = !rst_i && (miss || (state == ST_WRITEBACK) || (state == ST_REFILL));
        p1_data_o  = (!rst_i && access_ok) ? rd_word : '0;
    end

    // Miss-handling FSM with registered memory-side outputs held steady until acknowledged.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state        <= ST_IDLE;
            mem_enable_o <= 1'b0;
            mem_write_o  <= 1'b0;
            mem_addr_o   <= '0;
            mem_data_o   <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (miss) begin
                        mem_enable_o <= 1'b1;
                        if (rd_valid && rd_dirty) begin
                            state       <= ST_WRITEBACK;
                            mem_write_o <= 1'b1;
                            mem_addr_o  <= line_addr(rd_tag, idx);
                            mem_data_o  <= rd_line;
                        end else begin
                            state       <= ST_REFILL;
                            mem_write_o <= 1'b0;
                            mem_addr_o  <= line_addr(tag, idx);
                            mem_data_o  <= '0;
                        end
                    end
                end
                ST_WRITEBACK: begin
                    if (mem_ack_i) begin
                        state       <= ST_REFILL;
                        mem_write_o <= 1'b0;
                        mem_addr_o  <= line_addr(tag, idx);
                        mem_data_o  <= '0;
                    end
                end
                ST_REFILL: begin
                    if (mem_ack_i) begin
                        state        <= ST_DONE;
                        mem_enable_o <= 1'b0;
                        mem_addr_o   <= '0;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef DCACHE_STATS_EN
    // Saturating hit/miss counters sampled only on first evaluation in IDLE, so replays are not counted.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            hit_cnt_o  <= '0;
            miss_cnt_o <= '0;
        end else begin
            if ((state == ST_IDLE) && p1_req_i && hit && (hit_cnt_o != 32'hFFFF_FFFF))
                hit_cnt_o <= hit_cnt_o + 32'd1;
            if (miss && (miss_cnt_o != 32'hFFFF_FFFF))
                miss_cnt_o <= miss_cnt_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// Self-checking bench for dcache_ctrl: a latency-configurable memory responder,
// an architectural reference memory and a scoreboard of expected load data.
module tb_dcache_ctrl;

    localparam int LAT    = 2;
    localparam int BUDGET = 200;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] w0;
    } tx_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         p1_req;
    logic         p1_write;
    logic [31:0]  p1_addr;
    logic [31:0]  p1_wdata;
    logic [31:0]  p1_data_o;
    logic         p1_stall_o;
    logic         mem_enable_o;
    logic         mem_write_o;
    logic [31:0]  mem_addr_o;
    logic [255:0] mem_data_o;
    logic [255:0] mem_data_i;
    logic         mem_ack_i;
    logic         resp_ack;
    logic         stray_ack;
`ifdef DCACHE_STATS_EN
    logic [31:0]  hit_cnt_o;
    logic [31:0]  miss_cnt_o;
`endif

    int           errors = 0;
    int           checks = 0;
    int           last_stalls;
    logic [31:0]  exp_q [$];
    tx_t          tx_q [$];
    logic [31:0]  ref_mem [logic [31:0]];
    logic [255:0] bmem [logic [31:0]];

    assign mem_ack_i = resp_ack | stray_ack;

    always #5 clk = ~clk;

    dcache_ctrl dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .p1_req_i     (p1_req),
        .p1_write_i   (p1_write),
        .p1_addr_i    (p1_addr),
        .p1_data_i    (p1_wdata),
        .p1_data_o    (p1_data_o),
        .p1_stall_o   (p1_stall_o),
        .mem_enable_o (mem_enable_o),
        .mem_write_o  (mem_write_o),
        .mem_addr_o   (mem_addr_o),
        .mem_data_o   (mem_data_o),
        .mem_data_i   (mem_data_i),
        .mem_ack_i    (mem_ack_i)
`ifdef DCACHE_STATS_EN
        ,
        .hit_cnt_o    (hit_cnt_o),
        .miss_cnt_o   (miss_cnt_o)
`endif
    );

    // Initial contents of off-chip memory; word 0 of line 0x40 is a known constant.
    function automatic logic [31:0] init_word(input logic [31:0] a);
        if (a == 32'h40) return 32'h11;
        return {16'hC0DE, a[15:0]};
    endfunction

    function automatic logic [255:0] make_line(input logic [31:0] base);
        logic [255:0] l;
        for (int w = 0; w < 8; w++) l[w*32 +: 32] = init_word(base + 32'(4*w));
        return l;
    endfunction

    function automatic logic [31:0] ref_read(input logic [31:0] a);
        logic [31:0] wa;
        wa = {a[31:2], 2'b00};
        if (ref_mem.exists(wa)) return ref_mem[wa];
        return init_word(wa);
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
        end
    endtask

    task automatic checkTx(input string tag, input logic wr, input logic [31:0] addr,
                           input logic check_w0, input logic [31:0] w0);
        tx_t t;
        if (tx_q.size() == 0) begin
            checkOutput({tag, "_present"}, 32'd0, 32'd1);
        end else begin
            t = tx_q.pop_front();
            checkOutput({tag, "_wr"}, 32'(t.wr), 32'(wr));
            checkOutput({tag, "_addr"}, t.addr, addr);
            if (check_w0) checkOutput({tag, "_w0"}, t.w0, w0);
        end
    endtask

    // Drives one CPU access starting just after a rising edge, holds it through any stall,
    // compares load data against the scoreboard, and returns just after the consuming edge.
    task automatic applyStimulus(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                                 input string tag);
        int cyc;
        logic [31:0] exp;
        p1_req   = 1'b1;
        p1_write = wr;
        p1_addr  = addr;
        p1_wdata = wdata;
        if (wr) ref_mem[{addr[31:2], 2'b00}] = wdata;
        else    exp_q.push_back(ref_read(addr));
        cyc = 0;
        @(negedge clk);
        while (p1_stall_o && cyc < BUDGET) begin
            cyc++;
            @(negedge clk);
        end
        last_stalls = cyc;
        if (cyc >= BUDGET) begin
            checkOutput({tag, "_timeout"}, 32'd1, 32'd0);
            if (!wr && exp_q.size() > 0) void'(exp_q.pop_front());
        end else if (!wr) begin
            exp = exp_q.pop_front();
            checkOutput({tag, "_data"}, p1_data_o, exp);
        end
        @(posedge clk);
        #1;
        p1_req   = 1'b0;
        p1_write = 1'b0;
        p1_addr  = '0;
        p1_wdata = '0;
    endtask

    // Memory model: acknowledges each request LAT cycles after mem_enable_o is seen and logs it.
    initial begin
        int  cnt;
        tx_t t;
        resp_ack   = 1'b0;
        mem_data_i = '0;
        cnt        = 0;
        forever begin
            @(posedge clk);
            #1;
            if (resp_ack) begin
                resp_ack = 1'b0;
                cnt = mem_enable_o ? 1 : 0;
            end else if (mem_enable_o) begin
                cnt++;
                if (cnt >= LAT) begin
                    resp_ack = 1'b1;
                    t.wr   = mem_write_o;
                    t.addr = mem_addr_o;
                    t.w0   = mem_data_o[31:0];
                    tx_q.push_back(t);
                    if (mem_write_o) bmem[mem_addr_o] = mem_data_o;
                    else mem_data_i = bmem.exists(mem_addr_o) ? bmem[mem_addr_o] : make_line(mem_addr_o);
                end
            end else begin
                cnt = 0;
            end
        end
    end

    // Main sequence of directed accesses.
    initial begin
        rst = 1'b1; p1_req = 1'b0; p1_write = 1'b0; p1_addr = '0; p1_wdata = '0; stray_ack = 1'b0;
        #1;
        checkOutput("rst_stall", 32'(p1_stall_o), 32'd0);
        checkOutput("rst_enable", 32'(mem_enable_o), 32'd0);
        checkOutput("rst_write", 32'(mem_write_o), 32'd0);
        checkOutput("rst_addr", mem_addr_o, 32'd0);
        checkOutput("rst_data", p1_data_o, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checkOutput("idle_stall", 32'(p1_stall_o), 32'd0);
        checkOutput("idle_data", p1_data_o, 32'd0);
        @(posedge clk);
        #1;

        $display("[TB] test 1: cold load miss");
        applyStimulus(1'b0, 32'h40, 32'h0, "t1");
        checkOutput("t1_stalls", 32'(last_stalls), 32'(LAT + 1));
        checkTx("t1_tx", 1'b0, 32'h40, 1'b0, 32'h0);

        $display("[TB] test 2: load hit");
        applyStimulus(1'b0, 32'h44, 32'h0, "t2");
        checkOutput("t2_stalls", 32'(last_stalls), 32'd0);

        $display("[TB] test 3: store hit then dirty eviction");
        applyStimulus(1'b1, 32'h40, 32'hDEAD_BEEF, "t3s");
        checkOutput("t3s_stalls", 32'(last_stalls), 32'd0);
        applyStimulus(1'b0, 32'h440, 32'h0, "t3l");
        checkOutput("t3l_stalls", 32'(last_stalls), 32'(2*LAT + 1));
        checkTx("t3_wb", 1'b1, 32'h40, 1'b1, 32'hDEAD_BEEF);
        checkTx("t3_rf", 1'b0, 32'h440, 1'b0, 32'h0);

        $display("[TB] test 4: store miss with merge");
        applyStimulus(1'b1, 32'h80, 32'hCAFE_F00D, "t4s");
        checkOutput("t4s_stalls", 32'(last_stalls), 32'(LAT + 1));
        checkTx("t4_rf", 1'b0, 32'h80, 1'b0, 32'h0);
        applyStimulus(1'b0, 32'h80, 32'h0, "t4l");
        checkOutput("t4l_stalls", 32'(last_stalls), 32'd0);

        $display("[TB] stray ack in IDLE");
        stray_ack = 1'b1;
        @(posedge clk);
        #1 stray_ack = 1'b0;
        @(negedge clk);
        checkOutput("stray_enable", 32'(mem_enable_o), 32'd0);
        checkOutput("stray_stall", 32'(p1_stall_o), 32'd0);
        @(posedge clk);
        #1;
`ifdef DCACHE_STATS_EN
        checkOutput("hit_cnt", hit_cnt_o, 32'd3);
        checkOutput("miss_cnt", miss_cnt_o, 32'd3);
`endif

        $display("[TB] written-back line reloads");
        applyStimulus(1'b0, 32'h40, 32'h0, "wbrl");
        checkOutput("wbrl_stalls", 32'(last_stalls), 32'(LAT + 1));
        checkTx("wbrl_rf", 1'b0, 32'h40, 1'b0, 32'h0);
        applyStimulus(1'b0, 32'h5C, 32'h0, "wbrl_w7");

        $display("[TB] test 5: reset during refill");
        p1_req = 1'b1; p1_write = 1'b0; p1_addr = 32'h100; p1_wdata = '0;
        @(negedge clk);
        checkOutput("t5_miss_stall", 32'(p1_stall_o), 32'd1);
        @(posedge clk);
        @(negedge clk);
        checkOutput("t5_refill_enable", 32'(mem_enable_o), 32'd1);
        rst = 1'b1;
        #1;
        checkOutput("t5_rst_enable", 32'(mem_enable_o), 32'd0);
        checkOutput("t5_rst_stall", 32'(p1_stall_o), 32'd0);
        checkOutput("t5_rst_data", p1_data_o, 32'd0);
`ifdef DCACHE_STATS_EN
        checkOutput("t5_rst_hit_cnt", hit_cnt_o, 32'd0);
`endif
        @(posedge clk);
        #1 rst = 1'b0;
        checkOutput("t5_no_tx", 32'(tx_q.size()), 32'd0);
        applyStimulus(1'b0, 32'h100, 32'h0, "t5r");
        checkOutput("t5r_stalls", 32'(last_stalls), 32'(LAT + 1));
        checkTx("t5r_rf", 1'b0, 32'h100, 1'b0, 32'h0);
        applyStimulus(1'b0, 32'h40, 32'h0, "t5_cold");
        checkOutput("t5_cold_stalls", 32'(last_stalls), 32'(LAT + 1));

        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
